// File: rtl/byte_serial_add_32b.sv
// byte_serial_add_32b: multi-cycle add/subtract that walks an 8-bit carry-lookahead slice
// over the operands LSB byte first, chaining the slice carry between cycles.
module carry_lookahead_8b (
   input  logic [7:0] reg_a,
   input  logic [7:0] reg_b,
   input  logic       carryin,
   output logic [7:0] sum,
   output logic       carry_out
);
   logic [7:0] g, p;
   logic [8:0] c;
   function automatic logic [7:0] low_mask(input int n);
      return 8'((9'd1 << n) - 9'd1);
   endfunction
   assign g = reg_a & reg_b;
   assign p = reg_a ^ reg_b;
   // Each carry is a flat sum of generate terms propagated through the bits above them.
   always_comb begin
      c = '0;
      c[0] = carryin;
      for (int i = 0; i < 8; i++) begin
         c[i + 1] = carryin & (&(p | ~low_mask(i + 1)));
         for (int j = 0; j <= i; j++)
            c[i + 1] = c[i + 1] | (g[j] & (&(p | ~(low_mask(i + 1) & ~low_mask(j + 1)))));
      end
   end
   assign sum = p ^ c[7:0];
   assign carry_out = c[8];
endmodule

module byte_serial_add_32b #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);
   localparam int NSLICE = WIDTH / 8;
   localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] a_r, b_r, next_result;
   logic cin_r, accept, s_co;
   logic [7:0] s_a, s_b, s_sum;
   assign accept = start & ready;
   assign s_a = a_r[cnt*8 +: 8];
   assign s_b = b_r[cnt*8 +: 8];
   carry_lookahead_8b u_cla (
      .reg_a(s_a),
      .reg_b(s_b),
      .carryin(cin_r),
      .sum(s_sum),
      .carry_out(s_co)
   );
   always_comb begin
      next_result = result;
      next_result[cnt*8 +: 8] = s_sum;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         a_r <= '0;
         b_r <= '0;
         cin_r <= 1'b0;
         ready <= 1'b1;
         busy <= 1'b0;
         done <= 1'b0;
         result <= '0;
         carry_out <= 1'b0;
         overflow <= 1'b0;
         zero <= 1'b0;
      end else if (accept) begin
         state <= RUN;
         cnt <= '0;
         a_r <= op_a;
         b_r <= sub ? ~op_b : op_b;
         cin_r <= sub;
         ready <= 1'b0;
         busy <= 1'b1;
         done <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            RUN: begin
               result <= next_result;
               cin_r <= s_co;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= DONE;
                  ready <= 1'b1;
                  busy <= 1'b0;
                  done <= 1'b1;
                  carry_out <= s_co;
                  overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (s_sum[7] != a_r[WIDTH-1]);
                  zero <= ~|next_result;
               end
            end
            DONE: begin
               state <= IDLE;
               done <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_byte_serial_add_32b.sv
// tb_byte_serial_add_32b: scoreboard bench; expected results are queued on each accepted
// start and compared when done pulses.
module tb_byte_serial_add_32b;
   logic clk = 0, reset = 1, start = 0, sub = 0;
   logic [31:0] op_a = 0, op_b = 0;
   logic ready, busy, done, carry_out, overflow, zero;
   logic [31:0] result;
   int checks = 0, errors = 0, cyc = 0;
   typedef struct {
      logic [31:0] res;
      logic co, ov, z;
      int acc;
   } exp_t;
   exp_t q[$];

   byte_serial_add_32b dut (
      .clk(clk), .reset(reset), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
      .ready(ready), .busy(busy), .done(done), .result(result),
      .carry_out(carry_out), .overflow(overflow), .zero(zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t e;
      logic [31:0] bb;
      logic [32:0] t;
      bb = s ? ~b : b;
      t = {1'b0, a} + {1'b0, bb} + 33'(s);
      e.res = t[31:0];
      e.co = t[32];
      e.ov = (a[31] == bb[31]) && (t[31] != a[31]);
      e.z = (t[31:0] == 0);
      e.acc = 0;
      return e;
   endfunction

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ready) check("ready_timeout", 32'(ready), 1);
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t e;
      wait_ready();
      op_a = a;
      op_b = b;
      sub = s;
      start = 1;
      @(posedge clk);
      #1;
      e = model(a, b, s);
      e.acc = cyc;
      q.push_back(e);
      start = 0;
      op_a = $urandom;
      op_b = $urandom;
      sub = 1'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(q.size()), 0);
   endtask

   always @(negedge clk) begin
      if (done) begin
         if (q.size() == 0) check("spurious_done", 32'(q.size()), 1);
         else begin
            exp_t e;
            e = q.pop_front();
            check("result", result, e.res);
            check("carry_out", 32'(carry_out), 32'(e.co));
            check("overflow", 32'(overflow), 32'(e.ov));
            check("zero", 32'(zero), 32'(e.z));
            check("latency", 32'(cyc - e.acc), 4);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_result", result, 0);
      check("rst_flags", {29'd0, carry_out, overflow, zero}, 0);
      reset = 0;
      issue(32'hFFFFFFFF, 32'h1, 0);
      drain();
      issue(32'd5, 32'd7, 1);
      drain();
      issue(32'h7FFFFFFF, 32'h1, 0);
      drain();
      issue(32'h80000000, 32'h1, 1);
      drain();
      // A start during RUN must be ignored entirely.
      issue(32'h000000FF, 32'h1, 0);
      @(posedge clk);
      #1;
      op_a = 32'h12345678;
      op_b = 32'h11111111;
      sub = 1;
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
      check("busy_ignored_start", 32'(busy), 1);
      drain();
      check("held_result", result, 32'h00000100);
      // Reset in the middle of a run aborts it without a done pulse.
      wait_ready();
      op_a = 32'hDEADBEEF;
      op_b = 32'h01020304;
      sub = 0;
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
      @(posedge clk);
      #1;
      check("mid_busy", 32'(busy), 1);
      reset = 1;
      #1;
      check("async_ready", 32'(ready), 1);
      check("async_busy", 32'(busy), 0);
      check("async_result", result, 0);
      check("async_done", 32'(done), 0);
      @(negedge clk);
      reset = 0;
      issue(32'd3, 32'd4, 0);
      drain();
      for (int i = 0; i < 1000; i++) issue($urandom, $urandom, 1'($urandom));
      drain();
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got %0d expected 0", q.size());
      $fatal(1, "timeout");
   end
endmodule
